multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the 8-bit-PC ARM-subset processor. It takes the decoder's instruction fields and the ALU's NZCV flags, and drives the PC, instruction-register, register-file, data-RAM and mux controls one state at a time. It also owns the architectural flags register and evaluates condition codes. It replaces the hard-wired enables and mux selects in the processor top.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_fsm_if.sv | 42 ++++
 rtl/multicycle_ctrl_fsm_cond_check.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle ARM-subset sequencer.
//   state_t            - sequencer states
//   ALU_* / SRCA_* / SRCB_* / RES_* / IMM_*  - datapath control encodings
//   OP_* / OPC_* / COND_*                    - instruction field constants
//   dp_legal()         - DP opcode is one the datapath implements
//   dp_alu_ctrl()      - DP opcode to ALU operation
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, ALU_WB,
        MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_ORR    = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam logic [1:0] SRCA_RD1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RAM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic dp_legal(input logic [3:0] opc);
        case (opc)
            OPC_AND, OPC_SUB, OPC_ADD, OPC_CMP, OPC_ORR, OPC_MOV: dp_legal = 1'b1;
            default:                                              dp_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] dp_alu_ctrl(input logic [3:0] opc);
        case (opc)
            OPC_AND:          dp_alu_ctrl = ALU_AND;
            OPC_SUB, OPC_CMP: dp_alu_ctrl = ALU_SUB;
            OPC_ORR:          dp_alu_ctrl = ALU_ORR;
            OPC_MOV:          dp_alu_ctrl = ALU_PASS_B;
            default:          dp_alu_ctrl = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the sequencer and the processor datapath.
//   Decoder fields (cond/op/i_bit/opcode/s_bit/l_bit), alu_flags, mem_ready,
//   start and halt flow into the sequencer; enables, mux selects, flags_q,
//   busy and illegal flow out.
//   master: sequencer side.  slave: datapath side.
interface multicycle_ctrl_fsm_if;
    logic       start;
    logic       halt;
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic       l_bit;
    logic [3:0] alu_flags;
    logic       mem_ready;

    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       ram_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [3:0] flags_q;
    logic       busy;
    logic       illegal;

    modport master (
        input  start, halt, cond, op, i_bit, opcode, s_bit, l_bit, alu_flags, mem_ready,
        output pc_we, ir_we, rf_we, ram_we, alu_src_a, alu_src_b, alu_ctrl,
               result_src, imm_src, flags_q, busy, illegal
    );

    modport slave (
        output start, halt, cond, op, i_bit, opcode, s_bit, l_bit, alu_flags, mem_ready,
        input  pc_we, ir_we, rf_we, ram_we, alu_src_a, alu_src_b, alu_ctrl,
               result_src, imm_src, flags_q, busy, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_cond_check.sv
// cond_check: combinational ARM condition-code evaluation.
//   i_cond  - instruction bits 31:28
//   i_flags - NZCV
//   o_pass  - instruction should execute
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);
    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = i_flags;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;    // NV: never
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle sequencer for the 8-bit-PC ARM-subset core.
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - control bus (master side): instruction fields, ALU flags and
//          mem_ready in; datapath enables/selects, flags_q, busy, illegal out.
//   MEM_WAIT_MAX - wait cycles before a stalled RAM access is abandoned
//   COND_EN      - 0 executes every instruction unconditionally
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter bit COND_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);
    state_t     r_state, w_next;
    logic [7:0] r_wait_cnt;
    logic [3:0] r_flags;
    logic [3:0] r_alu_flags;

    logic       w_cc_pass, w_pass, w_timeout;
    state_t     w_boundary;

    logic       w_pc_we, w_ir_we, w_rf_we, w_ram_we, w_illegal;
    logic [1:0] w_src_a, w_src_b, w_res_src, w_imm_src;
    logic [2:0] w_alu_ctrl;

    cond_check u_cond (
        .i_cond  (bus.cond),
        .i_flags (r_flags),
        .o_pass  (w_cc_pass)
    );

    assign w_pass = COND_EN ? w_cc_pass : 1'b1;

    // Last allowed wait cycle with no ready: give up this cycle.
    assign w_timeout  = !bus.mem_ready && (r_wait_cnt == 8'(MEM_WAIT_MAX - 1));

    // Every path that would go back to FETCH honours halt instead.
    assign w_boundary = bus.halt ? IDLE : FETCH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_flags     <= '0;
            r_alu_flags <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_ADDR)
                r_wait_cnt <= '0;
            else if ((r_state == MEM_READ || r_state == MEM_WRITE) && !bus.mem_ready)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            // ALU flags are combinational; capture them while EXEC drives the ALU.
            if (r_state == EXEC)
                r_alu_flags <= bus.alu_flags;
            if (r_state == ALU_WB && (bus.s_bit || bus.opcode == OPC_CMP))
                r_flags <= r_alu_flags;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_ram_we   = 1'b0;
        w_illegal  = 1'b0;
        w_src_a    = SRCA_RD1;
        w_src_b    = SRCB_RD2;
        w_alu_ctrl = ALU_ADD;
        w_res_src  = RES_ALUOUT;
        w_imm_src  = IMM_DP;
        case (r_state)
            IDLE: if (bus.start) w_next = FETCH;
            FETCH: begin
                w_ir_we   = 1'b1;
                w_pc_we   = 1'b1;
                w_src_a   = SRCA_PC;
                w_src_b   = SRCB_FOUR;
                w_res_src = RES_ALU;
                w_next    = DECODE;
            end
            DECODE: begin
                if (!w_pass) begin
                    w_next = w_boundary;
                end else if (bus.op == OP_ILL || (bus.op == OP_DP && !dp_legal(bus.opcode))) begin
                    w_illegal = 1'b1;
                    w_next    = w_boundary;
                end else begin
                    case (bus.op)
                        OP_DP:   w_next = EXEC;
                        OP_MEM:  w_next = MEM_ADDR;
                        default: w_next = BRANCH;
                    endcase
                end
            end
            EXEC: begin
                w_src_b    = bus.i_bit ? SRCB_IMM : SRCB_RD2;
                w_alu_ctrl = dp_alu_ctrl(bus.opcode);
                w_next     = ALU_WB;
            end
            ALU_WB: begin
                w_rf_we = (bus.opcode != OPC_CMP);
                w_next  = w_boundary;
            end
            MEM_ADDR: begin
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_MEM;
                w_next    = bus.l_bit ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                if (bus.mem_ready) begin
                    w_next = MEM_WB;
                end else if (w_timeout) begin
                    w_illegal = 1'b1;
                    w_next    = w_boundary;
                end
            end
            MEM_WRITE: begin
                w_ram_we = 1'b1;
                if (bus.mem_ready) begin
                    w_next = w_boundary;
                end else if (w_timeout) begin
                    w_illegal = 1'b1;
                    w_next    = w_boundary;
                end
            end
            MEM_WB: begin
                w_res_src = RES_RAM;
                w_rf_we   = 1'b1;
                w_next    = w_boundary;
            end
            BRANCH: begin
                w_src_a   = SRCA_PC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_BR;
                w_res_src = RES_ALU;
                w_pc_we   = 1'b1;
                w_next    = w_boundary;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.pc_we      = w_pc_we;
    assign bus.ir_we      = w_ir_we;
    assign bus.rf_we      = w_rf_we;
    assign bus.ram_we     = w_ram_we;
    assign bus.alu_src_a  = w_src_a;
    assign bus.alu_src_b  = w_src_b;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.result_src = w_res_src;
    assign bus.imm_src    = w_imm_src;
    assign bus.flags_q    = r_flags;
    assign bus.busy       = (r_state != IDLE);
    assign bus.illegal    = w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction is expanded into its
// expected per-cycle control pattern from the ISA-level rules, then driven
// cycle by cycle with random side inputs and compared.
module tb_multicycle_ctrl_fsm;
    localparam int WMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.MEM_WAIT_MAX(WMAX), .COND_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [3:0] mflags = 4'h0;

    typedef struct {
        logic [16:0] e;
        bit          mr;
        bit [3:0]    af;
        bit          fw;
        bit [3:0]    fn;
    } cyc_t;
    cyc_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.pc_we, bus.ir_we, bus.rf_we, bus.ram_we, bus.alu_src_a, bus.alu_src_b,
                bus.alu_ctrl, bus.result_src, bus.imm_src, bus.busy, bus.illegal};
    endfunction

    function automatic logic [16:0] ev(bit pc, bit ir, bit rf, bit ram, bit [1:0] a, bit [1:0] b,
                                       bit [2:0] c, bit [1:0] rs, bit [1:0] imm, bit ill);
        return {pc, ir, rf, ram, a, b, c, rs, imm, 1'b1, ill};
    endfunction

    function automatic bit cpass(bit [3:0] cc, bit [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [2:0] opc_alu(bit [3:0] opc);
        case (opc)
            4'b0000: return 3'b010;
            4'b0010: return 3'b001;
            4'b1010: return 3'b001;
            4'b1100: return 3'b011;
            4'b1101: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Drive one cycle's inputs (we are just past a rising edge), check at the
    // falling edge, then move to just past the next rising edge.
    task automatic step(input logic [16:0] e, input bit mr, input bit [3:0] af, input bit st,
                        input bit fw, input bit [3:0] fn);
        bus.mem_ready = mr;
        bus.alu_flags = af;
        bus.start     = st;
        @(negedge clk);
        chk("outs", {15'd0, outs()}, {15'd0, e});
        chk("flags_q", {28'd0, bus.flags_q}, {28'd0, mflags});
        if (fw) mflags = fn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [16:0] e, input int mr, input bit [3:0] af, input bit fw, input bit [3:0] fn);
        cyc_t c;
        c.e  = e;
        c.mr = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
        c.af = af;
        c.fw = fw;
        c.fn = fn;
        q.push_back(c);
    endtask

    task automatic restart(input bit hl);
        repeat (1 + $urandom_range(0, 2))
            step(17'd0, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 1'b0, 4'h0);
        bus.halt = hl;    // start beats a simultaneous halt
        step(17'd0, 1'($urandom_range(0, 1)), 4'($urandom), 1'b1, 1'b0, 4'h0);
    endtask

    task automatic run_instr(input bit [3:0] cc, input bit [1:0] op, input bit ib, input bit [3:0] opc,
                             input bit s, input bit l, input int w, input bit h, input bit [3:0] afx);
        bit ok, bad, to;
        int n;
        bus.cond = cc; bus.op = op; bus.i_bit = ib; bus.opcode = opc;
        bus.s_bit = s; bus.l_bit = l; bus.halt = h;
        q.delete();
        push(ev(1, 1, 0, 0, 2'b01, 2'b10, 3'b000, 2'b10, 2'b00, 0), -1, 4'($urandom), 0, 0);
        ok  = cpass(cc, mflags);
        bad = ok && (op == 2'b11 || (op == 2'b00 &&
              !(opc inside {4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101})));
        push(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, bad), -1, 4'($urandom), 0, 0);
        if (ok && !bad) begin
            case (op)
                2'b00: begin
                    push(ev(0, 0, 0, 0, 2'b00, ib ? 2'b01 : 2'b00, opc_alu(opc), 0, 2'b00, 0), -1, afx, 0, 0);
                    push(ev(0, 0, opc != 4'b1010, 0, 0, 0, 0, 2'b00, 0, 0), -1, 4'($urandom),
                         s || opc == 4'b1010, afx);
                end
                2'b01: begin
                    push(ev(0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0, 2'b01, 0), -1, 4'($urandom), 0, 0);
                    to = (w >= WMAX);
                    n  = to ? WMAX : w + 1;
                    for (int k = 0; k < n; k++)
                        push(ev(0, 0, 0, !l, 0, 0, 0, 0, 0, to && k == n - 1), (k == w) ? 1 : 0,
                             4'($urandom), 0, 0);
                    if (l && !to)
                        push(ev(0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0), -1, 4'($urandom), 0, 0);
                end
                default:
                    push(ev(1, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b10, 2'b10, 0), -1, 4'($urandom), 0, 0);
            endcase
        end
        foreach (q[i])
            step(q[i].e, q[i].mr, q[i].af, 1'($urandom_range(0, 1)), q[i].fw, q[i].fn);
        if (h) restart(1'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.start = 0; bus.halt = 0; bus.cond = 0; bus.op = 0; bus.i_bit = 0;
        bus.opcode = 0; bus.s_bit = 0; bus.l_bit = 0; bus.alu_flags = 0; bus.mem_ready = 0;
        rst = 1'b0;
        repeat (3) begin
            bus.start = 1'b1;
            @(negedge clk);
            chk("reset_outs", {15'd0, outs()}, 32'd0);
            chk("reset_flags", {28'd0, bus.flags_q}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        restart(1'b0);

        // ADDS imm, AL, flags 0100
        run_instr(4'hE, 2'b00, 1, 4'b0100, 1, 0, 0, 0, 4'b0100);
        // ADDNE with Z set: skipped
        run_instr(4'h1, 2'b00, 0, 4'b0100, 1, 0, 0, 0, 4'b1111);
        // LDR with 3 wait cycles
        run_instr(4'hE, 2'b01, 0, 4'b0000, 0, 1, 3, 0, 4'h0);
        // STR that never completes
        run_instr(4'hE, 2'b01, 0, 4'b0000, 0, 0, 10, 0, 4'h0);
        // LDR that never completes
        run_instr(4'hE, 2'b01, 0, 4'b0000, 0, 1, 10, 0, 4'h0);
        // STR on the last allowed wait cycle
        run_instr(4'hE, 2'b01, 0, 4'b0000, 0, 0, WMAX - 1, 0, 4'h0);
        run_instr(4'hE, 2'b10, 0, 4'b0000, 0, 0, 0, 0, 4'h0);
        run_instr(4'hE, 2'b11, 0, 4'b0000, 0, 0, 0, 0, 4'h0);
        run_instr(4'hE, 2'b00, 0, 4'b0001, 0, 0, 0, 0, 4'h0);
        run_instr(4'hF, 2'b11, 0, 4'b0000, 0, 0, 0, 0, 4'h0);
        // CMP without S still writes flags, then halt
        run_instr(4'hE, 2'b00, 0, 4'b1010, 0, 0, 0, 1, 4'b0001);

        for (int i = 0; i < 250; i++) begin
            bit [3:0] cc, opc;
            bit [1:0] op;
            cc  = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
            op  = 2'($urandom);
            opc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5) * 2 + ($urandom_range(0, 5) == 5 ? 1 : 0))
                                              : 4'($urandom);
            run_instr(cc, op, 1'($urandom), opc, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 5), $urandom_range(0, 15) == 0, 4'($urandom));
        end

        // Reset in the middle of a stalled store.
        bus.cond = 4'hE; bus.op = 2'b01; bus.l_bit = 0; bus.halt = 0;
        step(ev(1, 1, 0, 0, 2'b01, 2'b10, 3'b000, 2'b10, 2'b00, 0), 0, 4'h0, 0, 0, 0);
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 4'h0, 0, 0, 0);
        step(ev(0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0, 2'b01, 0), 0, 4'h0, 0, 0, 0);
        step(ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 4'h0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        #1;
        chk("stall_ram_we", {31'd0, bus.ram_we}, 32'd1);
        rst = 1'b0;
        #1;
        mflags = 4'h0;
        chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_flags", {28'd0, bus.flags_q}, 32'd0);
        @(negedge clk);
        chk("rst_outs", {15'd0, outs()}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
